prefetch_buffer: RTL and testbench
==================================

# prefetch_buffer

Parametrised instruction prefetch buffer between the instruction cache and the IF stage. It streams word-aligned fetches from the icache into a circular queue of 16-bit parcels. It presents one complete instruction at a time: 16-bit compressed or 32-bit, aligned or straddling a word boundary. Compared with the fixed two-word prefetch, it adds configurable depth, back-to-back fetch, redirect with in-flight response discard, and a valid/ready output handshake.

## Interface
- XLEN, 32, address width.
- DEPTH_WORDS, 4, buffer capacity in 32-bit words. Power of two, ≥2. Parcel capacity CAP = 2*DEPTH_WORDS.
- RESET_PC, 32'h8000_0000, first fetch address after reset. Halfword aligned.
- clk  input  1  clock.
- reset  input  1  asynchronous, active-low reset.
- flush_i  input  1  redirect: discard buffer, restart at flush_pc_i.
- flush_pc_i  input  XLEN  redirect target. Bit 0 is ignored.
- ic_req_o  output  1  icache request. Held until ic_ack_i.
- ic_addr_o  output  XLEN  word-aligned fetch address. Stable while ic_req_o is high.
- ic_ack_i  input  1  icache response valid. Completes the current request.
- ic_data_i  input  32  fetched word. Little-endian parcels: [15:0] at addr, [31:16] at addr+2.
- instr_valid_o  output  1  instr_o holds a complete instruction.
- instr_ready_i  input  1  IF consumes the instruction when valid and ready are both high.
- instr_o  output  32  instruction. A compressed instruction is zero-extended: {16'b0, parcel}.
- instr_pc_o  output  XLEN  PC of instr_o.
- instr_is_comp_o  output  1  instr_o[1:0] != 2'b11.

## Operation
- Storage: CAP×16 parcel array. Read and write pointers are $clog2(CAP) bits and wrap modulo CAP. `count` is $clog2(CAP)+1 bits.
- Fetch address register `faddr` is word-aligned. It advances by 4 on each accepted ack that is not dropped.
- Request issue: assert ic_req_o when (count + 2 − pop_parcels) ≤ CAP − 2, not waiting for a dropped response, and not flushing this cycle.
  - Back-to-back: on an ack cycle, ic_req_o stays high with faddr+4 if the space test still passes after this write.
- Write on ack: both parcels are pushed (count += 2).
  - Exception: `skip_lo` is set, so only [31:16] is pushed (count += 1), then skip_lo clears.
- Decode: head parcel[1:0] != 2'b11 means compressed, needs 1 parcel. Otherwise it needs 2 parcels; the upper half is the next parcel, possibly wrapped.
- instr_valid_o = count ≥ needed parcels. Output is combinational from the array and head pointer.
- Pop on valid&ready: rd_ptr += 1 or 2, count −= 1 or 2, instr_pc += 2 or 4.
- Push and pop in the same cycle update count by the net amount.
- Flush, registered, takes priority over everything:
  - rd_ptr = wr_ptr = count = 0; instr_pc = flush_pc_i & ~1; faddr = flush_pc_i & ~3; skip_lo = flush_pc_i[1].
  - A pop in the same cycle is ignored.
  - An ack in the same cycle writes nothing.
  - If a request is outstanding and not acked this cycle, `drop` is set. ic_req_o stays high with the old address until ack, that data is discarded, then the new address is issued.
- Flush while drop is already set: only target state updates; drop remains set.
- Reset: all pointers and count 0; faddr = RESET_PC & ~3; instr_pc = RESET_PC; skip_lo = RESET_PC[1]; drop 0.

## Timing
- Reset values: ic_req_o 0, ic_addr_o RESET_PC & ~3, instr_valid_o 0, instr_o 0, instr_pc_o RESET_PC, instr_is_comp_o 0.
- First ic_req_o is asserted the cycle after reset deasserts.
- Ack in cycle N gives instr_valid_o in cycle N+1, when the data completes an instruction.
- Flush in cycle N with no outstanding request: ic_req_o at the new address in N+1; instr_valid_o is 0 in N+1.
- Sustained rate: one word per cycle with single-cycle acks and a consumer that is always ready.
- Full buffer: ic_req_o stays low; no overflow is possible.
- Empty buffer, or a 32-bit instruction with only its low half present: instr_valid_o is 0.
- instr_o is don't-care when instr_valid_o is 0. Bench checks it only when valid.

## Test plan
- Aligned stream: reset, icache returns 0x00000013, 0x00a00093, … with one-cycle ack, ready held high → IF receives instructions at PC 0x80000000, 0x80000004, …, one per cycle after the first.
- Mixed compressed: words 0x45014581, 0x00000013 → 0x00004581 @+0 (comp), 0x00004501 @+2 (comp), 0x00000013 @+4.
- Straddle: word0 = 0x00934501, word1 = 0x0000_00a0 → 0x00004501 @+0 (comp), then 0x00a00093 @+2 (not comp). Valid only after word1 is acked.
- Misaligned flush: flush_pc_i = 0x80000102 → ic_addr_o = 0x80000100. Low parcel is discarded; first output has PC 0x80000102 and holds data[31:16].
- Flush during an outstanding request: ack is delayed 3 cycles → old data is dropped; the next request targets the new address; no stale instruction reaches IF.
- Backpressure: ready=0 for 20 cycles with DEPTH_WORDS=4 → ic_req_o drops after 4 words are buffered. On release, 8 compressed instructions drain in order, then fetch resumes.

Source files
------------

// File: rtl/prefetch_buffer.sv
// Instruction prefetch buffer: streams icache words into a circular parcel queue and
// presents one complete (16- or 32-bit) instruction at a time to the IF stage.
module prefetch_buffer #(
    parameter int                XLEN        = 32,
    parameter int                DEPTH_WORDS = 4,
    parameter logic [XLEN-1:0]   RESET_PC    = 32'h8000_0000
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush_i,
    input  logic [XLEN-1:0] flush_pc_i,
    output logic            ic_req_o,
    output logic [XLEN-1:0] ic_addr_o,
    input  logic            ic_ack_i,
    input  logic [31:0]     ic_data_i,
    output logic            instr_valid_o,
    input  logic            instr_ready_i,
    output logic [31:0]     instr_o,
    output logic [XLEN-1:0] instr_pc_o,
    output logic            instr_is_comp_o
);
    localparam int CAP = 2 * DEPTH_WORDS;
    localparam int PW  = $clog2(CAP);
    localparam int CW  = PW + 1;

    logic [15:0]     pbuf [CAP];
    logic [PW-1:0]   rd_ptr, wr_ptr;
    logic [CW-1:0]   count;
    logic [XLEN-1:0] faddr, req_addr, pc_q;
    logic            skip_lo, drop, req_q;

    logic [15:0]     head, nxt;
    logic            is_comp, valid, pop, wr_en, hold, space_ok;
    logic [CW-1:0]   need, pop_n, push_n, count_nxt;
    logic [XLEN-1:0] faddr_nxt;

    always_comb begin
        head      = pbuf[rd_ptr];
        nxt       = pbuf[rd_ptr + PW'(1)];
        is_comp   = head[1:0] != 2'b11;
        need      = is_comp ? CW'(1) : CW'(2);
        valid     = count >= need;
        pop       = valid & instr_ready_i & ~flush_i;
        pop_n     = pop ? need : '0;
        // A response that belongs to a pre-flush request is never written
        wr_en     = req_q & ic_ack_i & ~drop & ~flush_i;
        push_n    = wr_en ? (skip_lo ? CW'(1) : CW'(2)) : '0;
        count_nxt = count + push_n - pop_n;
        space_ok  = count_nxt <= CW'(CAP - 2);
        hold      = req_q & ~ic_ack_i;
        faddr_nxt = wr_en ? faddr + XLEN'(4) : faddr;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < CAP; i++) pbuf[i] <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            faddr    <= RESET_PC & ~XLEN'(3);
            req_addr <= RESET_PC & ~XLEN'(3);
            pc_q     <= RESET_PC;
            skip_lo  <= RESET_PC[1];
            drop     <= 1'b0;
            req_q    <= 1'b0;
        end else if (flush_i) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            faddr    <= flush_pc_i & ~XLEN'(3);
            pc_q     <= flush_pc_i & ~XLEN'(1);
            skip_lo  <= flush_pc_i[1];
            // An unanswered request keeps its old address; its data is thrown away
            drop     <= hold;
            req_q    <= 1'b1;
            req_addr <= hold ? req_addr : (flush_pc_i & ~XLEN'(3));
        end else begin
            if (wr_en) begin
                if (skip_lo) begin
                    pbuf[wr_ptr] <= ic_data_i[31:16];
                    wr_ptr       <= wr_ptr + PW'(1);
                    skip_lo      <= 1'b0;
                end else begin
                    pbuf[wr_ptr]          <= ic_data_i[15:0];
                    pbuf[wr_ptr + PW'(1)] <= ic_data_i[31:16];
                    wr_ptr                <= wr_ptr + PW'(2);
                end
            end
            if (pop) begin
                rd_ptr <= rd_ptr + (is_comp ? PW'(1) : PW'(2));
                pc_q   <= pc_q + (is_comp ? XLEN'(2) : XLEN'(4));
            end
            if (req_q && ic_ack_i) drop <= 1'b0;
            count    <= count_nxt;
            faddr    <= faddr_nxt;
            req_q    <= hold | space_ok;
            req_addr <= hold ? req_addr : faddr_nxt;
        end
    end

    assign ic_req_o        = req_q;
    assign ic_addr_o       = req_addr;
    assign instr_valid_o   = valid;
    assign instr_o         = valid ? (is_comp ? {16'b0, head} : {nxt, head}) : 32'b0;
    assign instr_pc_o      = pc_q;
    assign instr_is_comp_o = valid & is_comp;
endmodule

// File: tb/tb_prefetch_buffer.sv
// Bench for prefetch_buffer: icache responder with variable latency, IF consumer, and an
// instruction-stream reference model that decodes straight from memory contents.
module tb_prefetch_buffer;
    logic        clk = 1'b0;
    logic        reset, flush, ack, ready;
    logic [31:0] flush_pc, data;
    logic        ic_req, instr_valid, instr_comp;
    logic [31:0] ic_addr, instr, instr_pc;

    always #5 clk = ~clk;

    prefetch_buffer #(.XLEN(32), .DEPTH_WORDS(4), .RESET_PC(32'h8000_0000)) dut (
        .clk(clk), .reset(reset), .flush_i(flush), .flush_pc_i(flush_pc),
        .ic_req_o(ic_req), .ic_addr_o(ic_addr), .ic_ack_i(ack), .ic_data_i(data),
        .instr_valid_o(instr_valid), .instr_ready_i(ready), .instr_o(instr),
        .instr_pc_o(instr_pc), .instr_is_comp_o(instr_comp)
    );

    logic [31:0] mem [256];
    int          errors = 0, checks = 0;
    int          lat = 0, wait_cnt = 0, ready_mode = 0, pops = 0, acks = 0;
    logic        stale = 1'b0;
    logic [31:0] exp_fa = 32'h8000_0000, exp_pc = 32'h8000_0000, old_addr;
    logic        found;

    function automatic logic [15:0] parcel(input logic [31:0] a);
        logic [31:0] w;
        w = mem[a[9:2]];
        return a[1] ? w[31:16] : w[15:0];
    endfunction

    function automatic logic ref_comp(input logic [31:0] pc);
        logic [15:0] lo;
        lo = parcel(pc);
        return lo[1:0] != 2'b11;
    endfunction

    function automatic logic [31:0] ref_instr(input logic [31:0] pc);
        return ref_comp(pc) ? {16'h0, parcel(pc)} : {parcel(pc + 32'd2), parcel(pc)};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // One clock: icache answers, IF consumes, optional redirect; returns #1 after the edge
    task automatic step(input logic do_flush, input logic [31:0] fpc);
        logic rdy;
        @(negedge clk);
        ack = 1'b0;
        if (ic_req) begin
            if (wait_cnt >= lat) begin
                ack = 1'b1;
                data = mem[ic_addr[9:2]];
                wait_cnt = 0;
                acks++;
                if (stale) stale = 1'b0;
                else begin
                    chk("fetch_addr", ic_addr, exp_fa);
                    exp_fa += 32'd4;
                end
            end else wait_cnt++;
        end
        case (ready_mode)
            0:       rdy = 1'b1;
            1:       rdy = 1'($urandom_range(0, 1));
            default: rdy = 1'b0;
        endcase
        ready = rdy;
        flush = do_flush;
        flush_pc = fpc;
        if (instr_valid && rdy && !do_flush) begin
            chk("instr", instr, ref_instr(exp_pc));
            chk("instr_pc", instr_pc, exp_pc);
            chk("is_comp", {31'b0, instr_comp}, {31'b0, ref_comp(exp_pc)});
            exp_pc += ref_comp(exp_pc) ? 32'd2 : 32'd4;
            pops++;
        end
        if (do_flush) begin
            stale  = ic_req && !ack;
            exp_fa = fpc & ~32'd3;
            exp_pc = fpc & ~32'd1;
        end
        @(posedge clk);
        #1;
        ack = 1'b0;
        flush = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        mem[0] = 32'h0000_0013; mem[1] = 32'h00a0_0093; mem[2] = 32'h4501_4581;
        mem[3] = 32'h0000_0013; mem[4] = 32'h0093_4501; mem[5] = 32'h0000_00a0;
        mem[64] = 32'h4501_9876;
        for (int i = 0; i < 4; i++)
            mem[192 + i] = {16'h0005 | 16'(i << 4), 16'h0001 | 16'(i << 4)};

        reset = 1'b0; flush = 1'b0; ack = 1'b0; ready = 1'b0; flush_pc = '0; data = '0;
        repeat (2) @(negedge clk);
        chk("rst_req", {31'b0, ic_req}, 32'd0);
        chk("rst_addr", ic_addr, 32'h8000_0000);
        chk("rst_valid", {31'b0, instr_valid}, 32'd0);
        chk("rst_instr", instr, 32'd0);
        chk("rst_pc", instr_pc, 32'h8000_0000);
        chk("rst_comp", {31'b0, instr_comp}, 32'd0);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("first_req", {31'b0, ic_req}, 32'd1);
        chk("first_addr", ic_addr, 32'h8000_0000);
        chk("first_valid", {31'b0, instr_valid}, 32'd0);

        // Aligned / compressed / straddle stream, single-cycle acks, always ready
        step(1'b0, '0);
        chk("ack_to_valid", {31'b0, instr_valid}, 32'd1);
        chk("first_instr", instr, 32'h0000_0013);
        for (int i = 0; i < 10; i++) step(1'b0, '0);
        chk("one_per_cycle", pops, 32'd10);

        // Misaligned redirect: low parcel of the first word is skipped
        step(1'b1, 32'h8000_0102);
        chk("flush_req", {31'b0, ic_req}, 32'd1);
        chk("flush_addr", ic_addr, 32'h8000_0100);
        chk("flush_valid", {31'b0, instr_valid}, 32'd0);
        step(1'b0, '0);
        chk("mis_valid", {31'b0, instr_valid}, 32'd1);
        chk("mis_instr", instr, 32'h0000_4501);
        chk("mis_pc", instr_pc, 32'h8000_0102);
        ready_mode = 1;
        for (int i = 0; i < 10; i++) step(1'b0, '0);

        // Redirect while a slow request is outstanding
        lat = 3;
        found = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            step(1'b0, '0);
            if (ic_req && wait_cnt == 1) found = 1'b1;
        end
        chk("drop_setup", {31'b0, found}, 32'd1);
        old_addr = ic_addr;
        step(1'b1, 32'h8000_0200);
        chk("drop_req_held", {31'b0, ic_req}, 32'd1);
        chk("drop_addr_held", ic_addr, old_addr);
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            step(1'b0, '0);
            if (!stale) found = 1'b1;
        end
        chk("drop_done", {31'b0, found}, 32'd1);
        chk("new_target", ic_addr, 32'h8000_0200);
        chk("new_req", {31'b0, ic_req}, 32'd1);
        for (int i = 0; i < 30; i++) step(1'b0, '0);

        // Backpressure: fill with compressed pairs, then drain
        lat = 0;
        ready_mode = 2;
        repeat (3) step(1'b0, '0);
        step(1'b1, 32'h8000_0300);
        acks = 0;
        for (int i = 0; i < 20; i++) step(1'b0, '0);
        chk("full_acks", acks, 32'd4);
        chk("full_req_low", {31'b0, ic_req}, 32'd0);
        chk("full_valid", {31'b0, instr_valid}, 32'd1);
        ready_mode = 0;
        pops = 0;
        for (int i = 0; i < 8; i++) step(1'b0, '0);
        chk("drain_pops", pops, 32'd8);
        chk("fetch_resumed", {31'b0, acks > 4}, 32'd1);

        // Random latency, ready and redirects
        ready_mode = 1;
        pops = 0;
        for (int i = 0; i < 600; i++) begin
            lat = $urandom_range(0, 2);
            if ($urandom_range(0, 39) == 0)
                step(1'b1, 32'h8000_0000 | ($urandom_range(0, 511) << 1));
            else
                step(1'b0, '0);
        end
        chk("random_progress", {31'b0, pops > 100}, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
